// File: rtl/game_state_history.sv
// Undo/redo snapshot buffer for Sokoban game states: four circular slots plus
// the slot select driving the downstream 4:1 game-state mux.
module game_state_history #(
   parameter int unsigned N = 134
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         init,
   input  logic [N-1:0] init_state,
   input  logic         push,
   input  logic [N-1:0] push_state,
   input  logic         undo,
   input  logic         redo,
   output logic [N-1:0] slot_0,
   output logic [N-1:0] slot_1,
   output logic [N-1:0] slot_2,
   output logic [N-1:0] slot_3,
   output logic [1:0]   sel,
   output logic [1:0]   undo_cnt,
   output logic [1:0]   redo_cnt,
   output logic         ack,
   output logic         nack
);

   localparam int unsigned CW       = 2;
   localparam int unsigned MAX_HIST = 3;

   logic [CW-1:0] sel_d;
   logic [CW-1:0] undo_cnt_d;
   logic [CW-1:0] redo_cnt_d;
   logic          ack_d;
   logic          nack_d;
   logic          wr_en;
   logic [CW-1:0] wr_idx;
   logic [N-1:0]  wr_data;

   // Command arbitration (init > undo > redo > push) and next-state computation
   always_comb begin
      sel_d      = sel;
      undo_cnt_d = undo_cnt;
      redo_cnt_d = redo_cnt;
      ack_d      = 1'b0;
      nack_d     = 1'b0;
      wr_en      = 1'b0;
      wr_idx     = sel + CW'(1);
      wr_data    = push_state;

      if (init) begin
         wr_en      = 1'b1;
         wr_idx     = '0;
         wr_data    = init_state;
         sel_d      = '0;
         undo_cnt_d = '0;
         redo_cnt_d = '0;
         ack_d      = 1'b1;
         nack_d     = undo | redo | push;
      end else if (undo) begin
         nack_d = redo | push;
         if (undo_cnt != '0) begin
            sel_d      = sel - CW'(1);
            undo_cnt_d = undo_cnt - CW'(1);
            redo_cnt_d = redo_cnt + CW'(1);
            ack_d      = 1'b1;
         end else begin
            nack_d = 1'b1;
         end
      end else if (redo) begin
         nack_d = push;
         if (redo_cnt != '0) begin
            sel_d      = sel + CW'(1);
            redo_cnt_d = redo_cnt - CW'(1);
            undo_cnt_d = undo_cnt + CW'(1);
            ack_d      = 1'b1;
         end else begin
            nack_d = 1'b1;
         end
      end else if (push) begin
         // Once history is full the oldest snapshot is silently overwritten
         wr_en      = 1'b1;
         sel_d      = sel + CW'(1);
         undo_cnt_d = (undo_cnt == CW'(MAX_HIST)) ? undo_cnt : undo_cnt + CW'(1);
         redo_cnt_d = '0;
         ack_d      = 1'b1;
      end
   end

   // Control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel      <= '0;
         undo_cnt <= '0;
         redo_cnt <= '0;
         ack      <= 1'b0;
         nack     <= 1'b0;
      end else begin
         sel      <= sel_d;
         undo_cnt <= undo_cnt_d;
         redo_cnt <= redo_cnt_d;
         ack      <= ack_d;
         nack     <= nack_d;
      end
   end

   // Snapshot slots; only init and push ever write them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_0 <= '0;
         slot_1 <= '0;
         slot_2 <= '0;
         slot_3 <= '0;
      end else if (wr_en) begin
         case (wr_idx)
            2'd0:    slot_0 <= wr_data;
            2'd1:    slot_1 <= wr_data;
            2'd2:    slot_2 <= wr_data;
            default: slot_3 <= wr_data;
         endcase
      end
   end

endmodule

// File: doc/game_state_history.md
Name: game_state_history

Overview:
- Writer side of the 4-slot game-state selection path: a 4-entry circular snapshot buffer for undo/redo of Sokoban moves.
- Captures committed N-bit game states into slots 0..3 and drives the slot contents plus the 2-bit slot select to the downstream 4:1 game-state mux.
- The mux output is the current game state.
- Sits between the move engine (producer of new states) and the mux/renderer.

Parameters:
- N, 134, width of one packed game-state snapshot.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- init  input  1  load a level: clears history and writes init_state.
- init_state  input  N  initial level state.
- push  input  1  commit a new state after a legal move.
- push_state  input  N  state to commit.
- undo  input  1  revert to the previous state.
- redo  input  1  re-apply the most recently undone state.
- slot_0  output  N  snapshot slot 0 (to mux in_0).
- slot_1  output  N  snapshot slot 1 (to mux in_1).
- slot_2  output  N  snapshot slot 2 (to mux in_2).
- slot_3  output  N  snapshot slot 3 (to mux in_3).
- sel  output  2  index of the slot holding the current state (to mux sel).
- undo_cnt  output  2  number of undo steps available, 0..3.
- redo_cnt  output  2  number of redo steps available, 0..3.
- ack  output  1  one-cycle pulse: the command this cycle was executed.
- nack  output  1  one-cycle pulse: the command was rejected or dropped.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous, any time including mid-command): all slots 0, sel=0, undo_cnt=0, redo_cnt=0, ack=0, nack=0.
- Commands are sampled on the rising edge. Results are visible on outputs one cycle later: new sel and slots in the same cycle, so the mux output is valid 1 cycle after the command.
- Command priority in one cycle: init > undo > redo > push. Exactly one command executes.
- Any lower-priority command asserted in the same cycle is dropped and nack pulses. ack also pulses if the winning command executed.
- init: slot[0] <= init_state; other slots unchanged; sel <= 0; undo_cnt <= 0; redo_cnt <= 0; ack.
- push: w = (sel+1) mod 4; slot[w] <= push_state; sel <= w; undo_cnt <= min(undo_cnt+1, 3); redo_cnt <= 0; ack.
  - When undo_cnt is already 3, the oldest snapshot is overwritten (wrap-around).
  - Push discards all redo history.
- undo:
  - If undo_cnt>0: sel <= (sel-1) mod 4; undo_cnt-1; redo_cnt+1; ack.
  - Else: no state change; nack.
- redo:
  - If redo_cnt>0: sel <= (sel+1) mod 4; redo_cnt-1; undo_cnt+1; ack.
  - Else: nack.
- Invariant: undo_cnt + redo_cnt <= 3 at all times. Slot contents are never modified by undo or redo.
- No command asserted: all registers hold; ack=nack=0.
- sel arithmetic is 2-bit modulo 4; 3+1 wraps to 0, 0-1 wraps to 3.
- Commands are level-sampled each cycle. A command held high for k cycles executes k times; upstream provides single-cycle pulses.

Test Plan:
- Reset, then init with state A -> slot_0=A, sel=0, undo_cnt=0, redo_cnt=0, ack for 1 cycle; a following undo -> nack, sel stays 0.
- init A, push B, C, D -> slot_1=B, slot_2=C, slot_3=D, sel=3, undo_cnt=3. Then 3 undos -> sel 2,1,0, redo_cnt=3. 4th undo -> nack.
- Wrap: init A, push B, C, D, E -> slot_0=E, sel=0, undo_cnt=3 (saturated). Then 3 undos -> sel=1 (B); 4th undo -> nack.
- Redo: init A, push B, C, undo, undo (sel=0, redo_cnt=2), redo -> sel=1, undo_cnt=1, redo_cnt=1. Then push X -> slot_2=X, sel=2, redo_cnt=0; a following redo -> nack.
- Simultaneous: undo and push asserted in the same cycle with undo_cnt=2 -> undo executes (sel-1), push_state not written, ack=1 and nack=1. init+undo together -> init executes.
- Asynchronous reset asserted mid-sequence (sel=2, undo_cnt=2), deasserted between edges -> all outputs 0 immediately. Next command push P -> slot_1=P, sel=1, undo_cnt=1.
